mux_tree_pipe: RTL
==================

# mux_tree_pipe

Parametrised, pipelined N-to-1 multiplexer tree with a valid pipeline, W-bit channels and an optional auto-scan select mode. It replaces flat combinational 16-to-1 trees wherever wide or deep selection must close timing at clock rate. Each 4:1 tree level is registered, and the select and valid travel alongside the data. A typical use is round-robin sampling of many sensor or register channels into one downstream consumer.

## Interface
- WIDTH, 8, bits per channel (≥1)
- CHANNELS, 16, number of input channels; power of 4, range 4..256
- LEVELS, derived = log4(CHANNELS), number of pipeline stages (not overridable)
- SEL_W, derived = 2*LEVELS, select width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- w  input  CHANNELS*WIDTH  packed channel data; channel i = w[i*WIDTH +: WIDTH]
- s  input  SEL_W  external channel select (used when mode=0)
- in_valid  input  1  sample w/s this cycle
- mode  input  1  0 = external select, 1 = auto-scan
- f  output  WIDTH  selected channel data
- out_valid  output  1  f/out_sel valid this cycle
- out_sel  output  SEL_W  channel index that produced f
- scan_wrap  output  1  high with out_valid for the last channel (CHANNELS-1) of an auto-scan sweep

## Operation
- Effective select: sel = mode ? scan_idx : s, sampled when in_valid=1.
- Level 0 picks among groups of 4 raw channels using sel[1:0], producing CHANNELS/4 results. It registers these results, the remaining sel bits, valid, and a wrap flag.
- Level k (1..LEVELS-1) picks among 4 level-(k-1) results using sel[2k+1:2k] and registers the result. The final level drives f.
- Data and sel registers in a stage load only when that stage's incoming valid is 1. Otherwise they hold. The valid bit always shifts.
- scan_idx (SEL_W bits):
  - Resets to 0.
  - While mode=1, it increments on each accepted sample (in_valid=1).
  - It wraps from CHANNELS-1 to 0.
  - While mode=0, it is forced to 0, so the next scan always starts at channel 0.
- The wrap flag is set for the sample where mode=1 and scan_idx=CHANNELS-1. It emerges as scan_wrap.
- A mode change applies to the sample taken in the same cycle. Samples already in flight are unaffected.
- The pipeline is fully throughput-capable: one sample per cycle, no backpressure.

## Timing
- Latency: a sample accepted at edge n appears with out_valid=1 after edge n+LEVELS-1. That is LEVELS register stages, so a CHANNELS=16 sample is visible 2 edges after it is presented.
- Bubbles (in_valid=0) propagate as out_valid=0. During a bubble, f and out_sel hold their last valid values.
- Reset values: f=0, out_valid=0, out_sel=0, scan_wrap=0. All stage valids and scan_idx are 0.
- Reset asserted mid-stream immediately discards all in-flight samples, with no valid output after it. The first sample after deassertion behaves as after power-up.
- Back-to-back samples with changing s produce back-to-back outputs, each tagged with its own out_sel.
- scan_wrap is high for exactly one cycle per sweep and is never high when out_valid=0.

## Structure
- Package mux_tree_pkg holds:
  - function clog4 (used to derive LEVELS)
  - localparam MAX_CHANNELS=256
  - a compile-time check that CHANNELS is a power of 4
- Sub-module mux4_stage (parameter WIDTH) is a registered 4:1 mux with load enable, with async reset of the data register to 0.
- The top instantiates mux4_stage instances: CHANNELS/4 at level 0, then /4 per level. Generate loops, valid/sel/wrap shift registers, and scan_idx live in the top.

## Test plan
- CHANNELS=16, WIDTH=8, w[i]=8'h10+i, mode=0; drive s=0..15 on consecutive cycles with in_valid=1 → out_valid=1 from the 2nd edge, f=8'h10..8'h1F in order, out_sel=0..15, scan_wrap=0.
- Same w, mode=1, in_valid=1 for 20 cycles → f=8'h10..8'h1F then 8'h10..8'h13; scan_wrap high only with f=8'h1F.
- in_valid pattern 1,0,1 with s=3, then s=7 → out_valid pattern 1,0,1; f holds 8'h13 during the bubble, then becomes 8'h17.
- Assert rst for one cycle while 2 samples are in flight → out_valid stays 0, f=0; a post-reset sample of s=5 gives f=8'h15 after latency.
- Switch mode 1→0 mid-scan at scan_idx=6, then back to 1 → the next scan begins at channel 0 (f=8'h10).
- CHANNELS=64, WIDTH=4, random w and s with random in_valid for 1000 cycles → f equals a scoreboard of w[s] delayed by 3 accepted-stage edges, and out_sel matches.

Source files
------------

// File: rtl/mux_tree_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_tree_pkg : shared sizing helpers for the pipelined mux tree      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package mux_tree_pkg;

  localparam int MAX_CHANNELS = 256;

  // Number of 4:1 levels needed to reduce n inputs to one.
  function automatic int clog4(input int n);
    int lvl;
    int span;
    lvl  = 0;
    span = 1;
    while (span < n) begin
      span = span * 4;
      lvl  = lvl + 1;
    end
    return lvl;
  endfunction

  function automatic bit is_pow4(input int n);
    int v;
    if (n < 1) return 1'b0;
    v = n;
    while ((v % 4) == 0) v = v / 4;
    return (v == 1);
  endfunction

  // Index of the first node of tree level 'level' in the flattened node vector.
  function automatic int node_base(input int channels, input int level);
    int base;
    int n;
    base = 0;
    n    = channels;
    for (int k = 0; k < level; k++) begin
      n    = n / 4;
      base = base + n;
    end
    return base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux4_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux4_stage : registered 4:1 multiplexer with load enable             |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module mux4_stage #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         sel,
  input  logic [4*WIDTH-1:0] d,
  output logic [WIDTH-1:0]   q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d[sel*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mux_tree_pipe : pipelined N-to-1 mux tree with valid/select pipeline |
// |                 and optional auto-scan select                        |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
import mux_tree_pkg::*;

module mux_tree_pipe #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 16,
  localparam int LEVELS   = clog4(CHANNELS),
  localparam int SEL_W    = 2 * LEVELS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] w,
  input  logic [SEL_W-1:0]          s,
  input  logic                      in_valid,
  input  logic                      mode,
  output logic [WIDTH-1:0]          f,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      scan_wrap
);

  localparam int               NODES    = node_base(CHANNELS, LEVELS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

  if (!is_pow4(CHANNELS) || (CHANNELS < 4) || (CHANNELS > MAX_CHANNELS) || (WIDTH < 1))
  begin : g_bad_params
    $error("mux_tree_pipe: CHANNELS must be a power of 4 in 4..256 and WIDTH >= 1");
  end

  logic [SEL_W-1:0]       scan_idx_q;
  logic [SEL_W-1:0]       scan_idx_d;
  logic [SEL_W-1:0]       sel_eff;
  logic                   wrap_eff;

  logic [LEVELS-1:0]      valid_q;
  logic [LEVELS-1:0]      valid_d;
  logic [LEVELS-1:0]      wrap_q;
  logic [LEVELS-1:0]      wrap_d;
  logic [SEL_W-1:0]       sel_q [LEVELS];
  logic [SEL_W-1:0]       sel_d [LEVELS];

  // Element k of each chain is what enters tree level k; element LEVELS is the output.
  logic [LEVELS:0]        valid_chain;
  logic [LEVELS:0]        wrap_chain;
  logic [SEL_W-1:0]       sel_chain [LEVELS+1];

  logic [NODES*WIDTH-1:0] node_data;

  always_comb begin
    sel_eff  = mode ? scan_idx_q : s;
    wrap_eff = mode && (scan_idx_q == LAST_IDX);

    // SEL_W exactly spans CHANNELS, so the increment wraps to 0 on its own.
    scan_idx_d = '0;
    if (mode) begin
      scan_idx_d = in_valid ? (scan_idx_q + SEL_W'(1)) : scan_idx_q;
    end
  end

  always_comb begin
    valid_chain  = {valid_q, in_valid};
    wrap_chain   = {wrap_q, wrap_eff};
    sel_chain[0] = sel_eff;
    for (int k = 0; k < LEVELS; k++) begin
      sel_chain[k+1] = sel_q[k];
    end

    for (int k = 0; k < LEVELS; k++) begin
      valid_d[k] = valid_chain[k];
      wrap_d[k]  = valid_chain[k] && wrap_chain[k];
      sel_d[k]   = valid_chain[k] ? sel_chain[k] : sel_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx_q <= '0;
      valid_q    <= '0;
      wrap_q     <= '0;
      for (int k = 0; k < LEVELS; k++) begin
        sel_q[k] <= '0;
      end
    end else begin
      scan_idx_q <= scan_idx_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      for (int k = 0; k < LEVELS; k++) begin
        sel_q[k] <= sel_d[k];
      end
    end
  end

  for (genvar lvl = 0; lvl < LEVELS; lvl++) begin : g_level
    localparam int COUNT    = CHANNELS >> (2 * (lvl + 1));
    localparam int OUT_BASE = node_base(CHANNELS, lvl);

    for (genvar j = 0; j < COUNT; j++) begin : g_node
      logic [4*WIDTH-1:0] node_in;

      if (lvl == 0) begin : g_from_ports
        assign node_in = w[j*4*WIDTH +: 4*WIDTH];
      end else begin : g_from_tree
        assign node_in = node_data[(node_base(CHANNELS, lvl - 1) + 4*j)*WIDTH +: 4*WIDTH];
      end

      mux4_stage #(
        .WIDTH (WIDTH)
      ) u_mux (
        .clk (clk),
        .rst (rst),
        .en  (valid_chain[lvl]),
        .sel (sel_chain[lvl][2*lvl +: 2]),
        .d   (node_in),
        .q   (node_data[(OUT_BASE + j)*WIDTH +: WIDTH])
      );
    end
  end

  assign f         = node_data[(NODES-1)*WIDTH +: WIDTH];
  assign out_valid = valid_chain[LEVELS];
  assign out_sel   = sel_chain[LEVELS];
  assign scan_wrap = wrap_chain[LEVELS];

endmodule
`default_nettype wire
